// File: rtl/fix_acc_stage.sv
// Saturating fixed-point accumulator for one CNN output pixel: bias + ACC_LEN
// product terms, saturated at every step, optional ReLU, valid/ready output.
module fix_acc_stage #(
    parameter int WIDTH   = 16,
    parameter int ACC_LEN = 25,
    parameter bit RELU    = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [WIDTH-1:0] bias,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_ovf
);

    localparam int CW = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;
    localparam logic [CW-1:0]    LAST_CNT = CW'(ACC_LEN - 1);
    localparam logic [WIDTH-1:0] MAX_VAL  = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic {
        ST_ACC  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_ovf_q, out_ovf_d;

    logic             accept;
    logic             first;
    logic             last;
    logic [WIDTH-1:0] base;
    logic [WIDTH:0]   sum;
    logic             step_ovf;
    logic             group_ovf;
    logic [WIDTH-1:0] sat;

    assign in_ready  = (state_q == ST_ACC);
    assign out_valid = (state_q == ST_HOLD);
    assign out_data  = out_data_q;
    assign out_ovf   = out_ovf_q;

    // The first term of a group is added to the bias instead of the running sum,
    // so a group never inherits anything from the previous one.
    always_comb begin
        accept    = in_valid & in_ready;
        first     = (cnt_q == '0);
        last      = (cnt_q == LAST_CNT);
        base      = first ? bias : acc_q;
        sum       = {base[WIDTH-1], base} + {in_data[WIDTH-1], in_data};
        step_ovf  = sum[WIDTH] ^ sum[WIDTH-1];
        group_ovf = first ? step_ovf : (ovf_q | step_ovf);
        if (step_ovf) begin
            sat = sum[WIDTH] ? MIN_VAL : MAX_VAL;
        end else begin
            sat = sum[WIDTH-1:0];
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        ovf_d      = ovf_q;
        out_data_d = out_data_q;
        out_ovf_d  = out_ovf_q;
        case (state_q)
            ST_ACC: begin
                if (accept) begin
                    if (last) begin
                        out_data_d = (RELU && sat[WIDTH-1]) ? '0 : sat;
                        out_ovf_d  = group_ovf;
                        cnt_d      = '0;
                        acc_d      = '0;
                        ovf_d      = 1'b0;
                        state_d    = ST_HOLD;
                    end else begin
                        acc_d = sat;
                        ovf_d = group_ovf;
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    state_d = ST_ACC;
                end
            end
            default: state_d = ST_ACC;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_ACC;
            cnt_q      <= '0;
            acc_q      <= '0;
            ovf_q      <= 1'b0;
            out_data_q <= '0;
            out_ovf_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            ovf_q      <= ovf_d;
            out_data_q <= out_data_d;
            out_ovf_q  <= out_ovf_d;
        end
    end

endmodule

// File: tb/tb_fix_acc_stage.sv
// Directed bench for fix_acc_stage: ReLU and pass-through copies with ACC_LEN=4
// share one input stream; a third copy covers ACC_LEN=1.
module tb_fix_acc_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        inValid;
    logic [15:0] inData;
    logic [15:0] biasIn;
    logic        outReady;

    logic        reluInReady, reluOutValid, reluOutOvf;
    logic [15:0] reluOutData;
    logic        linInReady, linOutValid, linOutOvf;
    logic [15:0] linOutData;

    logic        l1Valid, l1OutReady;
    logic [15:0] l1Data, l1Bias;
    logic        l1InReady, l1OutValid, l1OutOvf;
    logic [15:0] l1OutData;

    int assertCount = 0;
    int failCount   = 0;

    always #5 clk = ~clk;

    fix_acc_stage #(.WIDTH(16), .ACC_LEN(4), .RELU(1'b1)) u_dut_relu (
        .clk(clk), .rst_n(rst_n),
        .in_valid(inValid), .in_ready(reluInReady), .in_data(inData), .bias(biasIn),
        .out_valid(reluOutValid), .out_ready(outReady), .out_data(reluOutData), .out_ovf(reluOutOvf)
    );

    fix_acc_stage #(.WIDTH(16), .ACC_LEN(4), .RELU(1'b0)) u_dut_lin (
        .clk(clk), .rst_n(rst_n),
        .in_valid(inValid), .in_ready(linInReady), .in_data(inData), .bias(biasIn),
        .out_valid(linOutValid), .out_ready(outReady), .out_data(linOutData), .out_ovf(linOutOvf)
    );

    fix_acc_stage #(.WIDTH(16), .ACC_LEN(1), .RELU(1'b0)) u_dut_len1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(l1Valid), .in_ready(l1InReady), .in_data(l1Data), .bias(l1Bias),
        .out_valid(l1OutValid), .out_ready(l1OutReady), .out_data(l1OutData), .out_ovf(l1OutOvf)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Called #1 after a rising edge; the term is accepted on the next edge.
    task automatic applyStimulus(input logic [15:0] b, input logic [15:0] d);
        biasIn  = b;
        inData  = d;
        inValid = 1'b1;
        @(posedge clk); #1;
        inValid = 1'b0;
    endtask

    task automatic drainBoth(input string tag);
        outReady = 1'b1;
        @(posedge clk); #1;
        outReady = 1'b0;
        checkOutput({tag, "_relu_released"}, 32'(reluOutValid), 32'd0);
        checkOutput({tag, "_lin_released"},  32'(linOutValid),  32'd0);
    endtask

    initial begin
        rst_n      = 1'b0;
        inValid    = 1'b0;
        inData     = '0;
        biasIn     = '0;
        outReady   = 1'b0;
        l1Valid    = 1'b0;
        l1Data     = '0;
        l1Bias     = '0;
        l1OutReady = 1'b0;

        #3;
        checkOutput("rst_out_valid", 32'(reluOutValid), 32'd0);
        checkOutput("rst_out_data",  32'(reluOutData),  32'd0);
        checkOutput("rst_out_ovf",   32'(reluOutOvf),   32'd0);
        checkOutput("rst_in_ready",  32'(reluInReady),  32'd1);
        #9 rst_n = 1'b1;
        @(posedge clk); #1;

        // Group 1: 0x10 + 1 + 2 + 3 + 4 = 0x1A, result visible one cycle after last accept.
        applyStimulus(16'h0010, 16'd1);
        applyStimulus(16'h0010, 16'd2);
        applyStimulus(16'h0010, 16'd3);
        checkOutput("t1_valid_before_last", 32'(reluOutValid), 32'd0);
        applyStimulus(16'h0010, 16'd4);
        checkOutput("t1_valid_after_last", 32'(reluOutValid), 32'd1);
        checkOutput("t1_in_ready_hold",    32'(reluInReady),  32'd0);
        checkOutput("t1_data",             32'(reluOutData),  32'h001A);
        checkOutput("t1_ovf",              32'(reluOutOvf),   32'd0);
        checkOutput("t1_lin_data",         32'(linOutData),   32'h001A);
        drainBoth("t1");

        // Group 2: positive saturation at every step, then a clean group clears ovf.
        for (int i = 0; i < 4; i++) applyStimulus(16'h7000, 16'h1000);
        checkOutput("t2_sat_data", 32'(reluOutData), 32'h7FFF);
        checkOutput("t2_sat_ovf",  32'(reluOutOvf),  32'd1);
        drainBoth("t2a");
        for (int i = 0; i < 4; i++) applyStimulus(16'h0000, 16'h0001);
        checkOutput("t2_clean_data", 32'(reluOutData), 32'h0004);
        checkOutput("t2_clean_ovf",  32'(reluOutOvf),  32'd0);
        drainBoth("t2b");

        // Group 3: -4 is clamped by ReLU and passed through otherwise.
        for (int i = 0; i < 4; i++) applyStimulus(16'h0000, 16'hFFFF);
        checkOutput("t3_relu_data", 32'(reluOutData), 32'h0000);
        checkOutput("t3_relu_ovf",  32'(reluOutOvf),  32'd0);
        checkOutput("t3_lin_data",  32'(linOutData),  32'hFFFC);
        checkOutput("t3_lin_ovf",   32'(linOutOvf),   32'd0);
        drainBoth("t3");

        // ACC_LEN=1: negative saturation, then an ordinary single-term group.
        l1Bias = 16'h8000; l1Data = 16'hFFFF; l1Valid = 1'b1;
        @(posedge clk); #1;
        l1Valid = 1'b0;
        checkOutput("t4_valid", 32'(l1OutValid), 32'd1);
        checkOutput("t4_data",  32'(l1OutData),  32'h8000);
        checkOutput("t4_ovf",   32'(l1OutOvf),   32'd1);
        l1OutReady = 1'b1;
        @(posedge clk); #1;
        l1OutReady = 1'b0;
        checkOutput("t4_released", 32'(l1OutValid), 32'd0);
        l1Bias = 16'h0003; l1Data = 16'h0004; l1Valid = 1'b1;
        @(posedge clk); #1;
        l1Valid = 1'b0;
        checkOutput("t4b_data", 32'(l1OutData), 32'h0007);
        checkOutput("t4b_ovf",  32'(l1OutOvf),  32'd0);

        // Group 5: stalled HOLD ignores in_valid, including the handshake cycle.
        for (int i = 0; i < 4; i++) applyStimulus(16'h0000, 16'h0002);
        biasIn  = 16'h0100;
        inData  = 16'h0100;
        inValid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checkOutput("t5_hold_valid", 32'(reluOutValid), 32'd1);
            checkOutput("t5_hold_ready", 32'(reluInReady),  32'd0);
            checkOutput("t5_hold_data",  32'(reluOutData),  32'h0008);
        end
        outReady = 1'b1;
        @(posedge clk); #1;
        outReady = 1'b0;
        inValid  = 1'b0;
        checkOutput("t5_released", 32'(reluOutValid), 32'd0);
        for (int i = 0; i < 4; i++) applyStimulus(16'h0000, 16'h0005);
        checkOutput("t5_next_data", 32'(reluOutData), 32'h0014);
        checkOutput("t5_next_ovf",  32'(reluOutOvf),  32'd0);
        drainBoth("t5");

        // Group 6: async reset mid-group discards the partial sum.
        applyStimulus(16'h0100, 16'h0100);
        applyStimulus(16'h0100, 16'h0100);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("t6_rst_valid", 32'(reluOutValid), 32'd0);
        checkOutput("t6_rst_data",  32'(reluOutData),  32'd0);
        checkOutput("t6_rst_ovf",   32'(reluOutOvf),   32'd0);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) applyStimulus(16'h0001, 16'h0001);
        checkOutput("t6_next_data", 32'(reluOutData), 32'h0005);
        checkOutput("t6_next_ovf",  32'(reluOutOvf),  32'd0);
        drainBoth("t6");

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
